// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two
// requesters, with a single registered result slot.
//   clk, reset                  : clock, synchronous active-high reset
//   reqN_valid / reqN_ready     : requester N handshake (ready = granted now)
//   reqN_srca/srcb/ctrl         : requester N operands and ALU control code
//   alu_srca/alu_srcb/alu_ctrl  : granted operands to the shared ALU (0 if idle)
//   alu_result                  : combinational ALU result, captured on grant
//   rsp_valid/rsp_ready         : result slot handshake
//   rsp_id/rsp_result           : owner and value of the held result
module alu_arbiter #(
   parameter logic FIRST_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_srca,
   input  logic [31:0] req0_srcb,
   input  logic [2:0]  req0_ctrl,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_srca,
   input  logic [31:0] req1_srcb,
   input  logic [2:0]  req1_ctrl,
   output logic [31:0] alu_srca,
   output logic [31:0] alu_srcb,
   output logic [2:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t      r_state, w_next;
   logic        r_any;
   logic        r_last;
   logic        r_id;
   logic [31:0] r_result;
   logic        w_free;
   logic        w_pick1;
   logic        w_gnt0;
   logic        w_gnt1;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= EMPTY;
         r_any    <= 1'b0;
         r_last   <= 1'b0;
         r_id     <= 1'b0;
         r_result <= '0;
      end else begin
         r_state <= w_next;
         if (w_gnt0 | w_gnt1) begin
            r_any    <= 1'b1;
            r_last   <= w_gnt1;
            r_id     <= w_gnt1;
            r_result <= alu_result;
         end
      end
   end
   // The slot can refill in the same cycle it drains.
   // On a tie, favour the side not granted last, or FIRST_PRIO before any grant.
   always_comb begin
      w_next     = r_state;
      w_free     = (r_state == EMPTY) | rsp_ready;
      w_pick1    = r_any ? ~r_last : FIRST_PRIO;
      w_gnt0     = ~reset & w_free & req0_valid & (~req1_valid | ~w_pick1);
      w_gnt1     = ~reset & w_free & req1_valid & (~req0_valid | w_pick1);
      req0_ready = w_gnt0;
      req1_ready = w_gnt1;
      alu_srca   = w_gnt0 ? req0_srca : w_gnt1 ? req1_srca : '0;
      alu_srcb   = w_gnt0 ? req0_srcb : w_gnt1 ? req1_srcb : '0;
      alu_ctrl   = w_gnt0 ? req0_ctrl : w_gnt1 ? req1_ctrl : 3'b000;
      if (w_gnt0 | w_gnt1)
         w_next = FULL;
      else if (r_state == FULL && rsp_ready)
         w_next = EMPTY;
   end
   assign rsp_valid  = (r_state == FULL);
   assign rsp_id     = r_id;
   assign rsp_result = r_result;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized self-check of alu_arbiter against a behavioural model.
module tb_alu_arbiter;
   localparam logic FP = 1'b0;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
   logic [2:0]  req0_ctrl, req1_ctrl;
   logic [31:0] alu_srca, alu_srcb, alu_result, rsp_result;
   logic [2:0]  alu_ctrl;
   logic        rsp_valid, rsp_ready, rsp_id;
   int          n_vec = 0;
   int          n_err = 0;
   int          n_cmp = 0;
   bit          m_on = 1'b0;
   logic        m_full, m_id, m_any, m_last;
   logic [31:0] m_res;
   int          m_wait [2];

   alu_arbiter #(.FIRST_PRIO(FP)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_ctrl(req1_ctrl),
      .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] c);
      case (c)
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b000:  return a & b;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_srca, alu_srcb, alu_ctrl);

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Which requester the rules say must be granted right now (one-hot, 0 = none).
   function automatic logic [1:0] exp_gnt();
      logic [1:0] v;
      v = {req1_valid, req0_valid};
      if (reset || (m_full && !rsp_ready) || v == 2'b00) return 2'b00;
      if (v != 2'b11) return v;
      if (m_any) return m_last ? 2'b01 : 2'b10;
      return FP ? 2'b10 : 2'b01;
   endfunction

   always @(posedge clk) begin
      logic [1:0] g;
      logic       vn;
      g = exp_gnt();
      if (reset) begin
         m_on = 1'b1;
         m_full = 1'b0;
         m_id = 1'b0;
         m_res = 32'd0;
         m_any = 1'b0;
         m_last = 1'b0;
         m_wait[0] = 0;
         m_wait[1] = 0;
      end else if (m_on) begin
         if (g != 2'b00) begin
            m_id = g[1];
            m_res = g[1] ? alu_fn(req1_srca, req1_srcb, req1_ctrl) : alu_fn(req0_srca, req0_srcb, req0_ctrl);
            m_full = 1'b1;
            m_any = 1'b1;
            m_last = g[1];
         end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
         end
         for (int n = 0; n < 2; n++) begin
            vn = n ? req1_valid : req0_valid;
            if (!vn || g[n]) m_wait[n] = 0;
            else if (g != 2'b00) m_wait[n]++;
            chk("starvation", {31'd0, m_wait[n] <= 1}, 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      logic [1:0] g;
      if (m_on) begin
         g = exp_gnt();
         n_vec++;
         chk("req0_ready", {31'd0, req0_ready}, {31'd0, g[0]});
         chk("req1_ready", {31'd0, req1_ready}, {31'd0, g[1]});
         chk("alu_srca", alu_srca, g[0] ? req0_srca : g[1] ? req1_srca : 32'd0);
         chk("alu_srcb", alu_srcb, g[0] ? req0_srcb : g[1] ? req1_srcb : 32'd0);
         chk("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, g[0] ? req0_ctrl : g[1] ? req1_ctrl : 3'b000});
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
         chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
         chk("rsp_result", rsp_result, m_res);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setin(logic v0, logic [31:0] a0, logic [31:0] b0, logic [2:0] c0,
                        logic v1, logic [31:0] a1, logic [31:0] b1, logic [2:0] c1, logic rr);
      req0_valid = v0; req0_srca = a0; req0_srcb = b0; req0_ctrl = c0;
      req1_valid = v1; req1_srca = a1; req1_srcb = b1; req1_ctrl = c1;
      rsp_ready = rr;
      #1;
   endtask

   initial begin
      logic        p_v [2];
      logic [31:0] p_a [2];
      logic [31:0] p_b [2];
      logic [2:0]  p_c [2];
      logic        g0, g1;
      logic [2:0]  codes [4];
      codes[0] = 3'b010; codes[1] = 3'b110; codes[2] = 3'b000; codes[3] = 3'b000;
      setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      setin(1, 9, 9, 3'b010, 1, 4, 4, 3'b110, 1);
      chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("reset_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
      chk("reset_alu_srca", alu_srca, 32'd0);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      reset = 1'b0;
      setin(1, 5, 7, 3'b010, 0, 0, 0, 0, 1);
      chk("add_req0_ready", {31'd0, req0_ready}, 32'd1);
      chk("add_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("add_alu_ctrl", {29'd0, alu_ctrl}, 32'd2);
      chk("add_alu_srcb", alu_srcb, 32'd7);
      tick();
      setin(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("add_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("add_rsp_result", rsp_result, 32'd12);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         setin(1, 1, 2, 3'b010, 1, 10, 20, 3'b010, 1);
         chk("rr_req0_ready", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_req1_ready", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
         if (i > 0) begin
            chk("rr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rr_rsp_id", {31'd0, rsp_id}, ((i - 1) % 2 == 1) ? 32'd1 : 32'd0);
         end
         tick();
      end
      setin(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("rr_last_id", {31'd0, rsp_id}, 32'd1);
      chk("rr_last_result", rsp_result, 32'd30);
      setin(0, 0, 0, 0, 1, 3, 5, 3'b110, 1);
      chk("sub_req1_ready", {31'd0, req1_ready}, 32'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         setin(1, 5, 7, 3'b010, 0, 0, 0, 0, 0);
         chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_rsp_result", rsp_result, 32'hFFFFFFFE);
         chk("hold_rsp_id", {31'd0, rsp_id}, 32'd1);
         chk("hold_req0_ready", {31'd0, req0_ready}, 32'd0);
         chk("hold_req1_ready", {31'd0, req1_ready}, 32'd0);
         tick();
      end
      setin(1, 5, 7, 3'b010, 0, 0, 0, 0, 1);
      chk("drain_refill_ready0", {31'd0, req0_ready}, 32'd1);
      tick();
      setin(1, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 0, 0, 0, 0, 1);
      chk("refill_result", rsp_result, 32'd12);
      chk("and_req0_ready", {31'd0, req0_ready}, 32'd1);
      tick();
      setin(1, 32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 0, 0, 0, 0, 1);
      chk("and_result", rsp_result, 32'hF000F000);
      chk("undef_alu_ctrl", {29'd0, alu_ctrl}, 32'd1);
      tick();
      setin(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("undef_result", rsp_result, 32'd0);
      chk("undef_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      tick();
      setin(1, 1, 1, 3'b010, 0, 0, 0, 0, 0);
      tick();
      setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("full_before_reset", {31'd0, rsp_valid}, 32'd1);
      chk("full_result", rsp_result, 32'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      setin(1, 1, 2, 3'b010, 1, 10, 20, 3'b010, 1);
      chk("post_reset_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_reset_result", rsp_result, 32'd0);
      chk("post_reset_ready0", {31'd0, req0_ready}, FP ? 32'd0 : 32'd1);
      chk("post_reset_ready1", {31'd0, req1_ready}, FP ? 32'd1 : 32'd0);
      tick();
      p_v[0] = 1'b0;
      p_v[1] = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         for (int n = 0; n < 2; n++) begin
            if (!p_v[n] && $urandom_range(0, 2) != 0) begin
               p_v[n] = 1'b1;
               p_a[n] = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom;
               p_b[n] = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
               p_c[n] = $urandom_range(0, 7) == 0 ? 3'($urandom) : codes[$urandom_range(0, 3)];
            end
         end
         reset = ($urandom_range(0, 199) == 0);
         setin(p_v[0], p_a[0], p_b[0], p_c[0], p_v[1], p_a[1], p_b[1], p_c[1], $urandom_range(0, 3) != 0);
         g0 = req0_ready;
         g1 = req1_ready;
         tick();
         if (g0) p_v[0] = 1'b0;
         if (g1) p_v[1] = 1'b0;
      end
      reset = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
